lcd_seq: RTL and testbench



---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_seq_if.sv | 24 ++
 rtl/lcd_init_rom.sv | 19 +
 rtl/lcd_seq.sv | 142 ++++++++++++++
 tb/tb_lcd_seq.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared state encoding and HD44780 instruction constants for the LCD command sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_INIT,
    ST_READY,
    ST_CHAR,
    ST_ADDR,
    ST_CLR,
    ST_HOME
  } state_e;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DDRAM_L0 = 8'h80;
  localparam logic [7:0] LCD_DDRAM_L1 = 8'hC0;
  localparam logic [7:0] CHAR_NEWLINE = 8'h0A;
  localparam int         INIT_LEN     = 5;

  // RS=0 instruction word for the driver's 9-bit command port
  function automatic logic [8:0] instr(input logic [7:0] b);
    return {1'b0, b};
  endfunction

endpackage

// File: rtl/lcd_seq_if.sv
// Character-side and command-side handshakes of the LCD sequencer.
// master = sequencer, slave = the character source / LCD driver side.
interface lcd_seq_if;
  logic [7:0] char_i;
  logic       char_valid_i;
  logic       char_ready_o;
  logic       clear_i;
  logic [8:0] cmd_o;
  logic       cmd_valid_o;
  logic       cmd_ready_i;
  logic       init_done_o;
  logic [5:0] col_o;
  logic       line_o;

  modport master (
    input  char_i, char_valid_i, clear_i, cmd_ready_i,
    output char_ready_o, cmd_o, cmd_valid_o, init_done_o, col_o, line_o
  );

  modport slave (
    output char_i, char_valid_i, clear_i, cmd_ready_i,
    input  char_ready_o, cmd_o, cmd_valid_o, init_done_o, col_o, line_o
  );
endinterface

// File: rtl/lcd_init_rom.sv
// Power-on initialisation instruction table, indexed by step number.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] i_idx,
  output logic [7:0] o_data
);
  always_comb begin
    o_data = 8'h00;
    case (i_idx)
      3'd0:    o_data = LCD_FUNC_SET;
      3'd1:    o_data = LCD_FUNC_SET;
      3'd2:    o_data = LCD_DISP_ON;
      3'd3:    o_data = LCD_CLEAR;
      3'd4:    o_data = LCD_ENTRY;
      default: o_data = 8'h00;
    endcase
  end
endmodule

// File: rtl/lcd_seq.sv
// HD44780 command sequencer: init sequence, then chars -> data writes with cursor tracking.
// Optional power-on wait enabled by defining LCD_BOOT_DELAY_EN.
module lcd_seq
  import lcd_pkg::*;
#(
  parameter int COLS = 16
`ifdef LCD_BOOT_DELAY_EN
  , parameter int BOOT_CYCLES = 1_500_000
`endif
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  lcd_seq_if.master bus
);
  localparam logic [5:0] COLS_LAST = 6'(COLS - 1);
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

  state_e     r_state, w_state_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [5:0] r_col, w_col_nxt;
  logic       r_line, w_line_nxt;
  logic       r_clr_pend, r_init_done;
  logic [8:0] r_cmd, w_cmd_nxt;
  logic       r_cmd_valid, w_cmd_valid_nxt;
  logic       w_xfer, w_clr_req, w_char_ready, w_accept;
  logic [7:0] w_rom_data;

`ifdef LCD_BOOT_DELAY_EN
  localparam state_e     RST_STATE = ST_BOOT;
  localparam logic [20:0] BOOT_LAST = 21'(BOOT_CYCLES - 1);
  logic [20:0] r_boot_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i)                r_boot_cnt <= '0;
    else if (r_state == ST_BOOT) r_boot_cnt <= r_boot_cnt + 21'd1;
`else
  localparam state_e RST_STATE = ST_INIT;
`endif

  lcd_init_rom u_rom (.i_idx(w_idx_nxt), .o_data(w_rom_data));

  assign w_xfer       = r_cmd_valid & bus.cmd_ready_i;
  assign w_clr_req    = r_clr_pend | bus.clear_i;
  assign w_char_ready = (r_state == ST_READY) & ~w_clr_req;
  assign w_accept     = bus.char_valid_i & w_char_ready;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= RST_STATE;
      r_idx       <= '0;
      r_col       <= '0;
      r_line      <= 1'b0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_init_done <= 1'b0;
      r_clr_pend  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_col       <= w_col_nxt;
      r_line      <= w_line_nxt;
      r_cmd       <= w_cmd_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      if (r_state == ST_INIT && w_state_nxt == ST_READY) r_init_done <= 1'b1;
      // pulses arriving while a clear is in flight merge into it
      if (r_state == ST_HOME && w_xfer)       r_clr_pend <= 1'b0;
      else if (bus.clear_i && r_init_done)    r_clr_pend <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_col_nxt   = r_col;
    w_line_nxt  = r_line;
    unique case (r_state)
`ifdef LCD_BOOT_DELAY_EN
      ST_BOOT: if (r_boot_cnt == BOOT_LAST) w_state_nxt = ST_INIT;
`endif
      ST_INIT: if (w_xfer) begin
        if (r_idx == INIT_LAST) w_state_nxt = ST_READY;
        else                    w_idx_nxt   = r_idx + 3'd1;
      end
      ST_READY: begin
        if (w_clr_req) w_state_nxt = ST_CLR;
        else if (w_accept) begin
          if (bus.char_i == CHAR_NEWLINE) begin
            w_line_nxt  = ~r_line;
            w_col_nxt   = '0;
            w_state_nxt = ST_ADDR;
          end else begin
            w_state_nxt = ST_CHAR;
          end
        end
      end
      ST_CHAR: if (w_xfer) begin
        if (r_col == COLS_LAST) begin
          w_col_nxt   = '0;
          w_line_nxt  = ~r_line;
          w_state_nxt = ST_ADDR;
        end else begin
          w_col_nxt   = r_col + 6'd1;
          w_state_nxt = ST_READY;
        end
      end
      ST_ADDR: if (w_xfer) w_state_nxt = ST_READY;
      ST_CLR: if (w_xfer) begin
        w_col_nxt   = '0;
        w_line_nxt  = 1'b0;
        w_state_nxt = ST_HOME;
      end
      ST_HOME: if (w_xfer) w_state_nxt = ST_READY;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Load the next command only when the port is idle or the current one is taken,
  // so cmd_o stays frozen while the driver stalls.
  always_comb begin
    w_cmd_nxt       = r_cmd;
    w_cmd_valid_nxt = r_cmd_valid;
    if (!r_cmd_valid || w_xfer) begin
      w_cmd_valid_nxt = 1'b1;
      unique case (w_state_nxt)
        ST_INIT: w_cmd_nxt = instr(w_rom_data);
        ST_CHAR: w_cmd_nxt = {1'b1, bus.char_i};
        ST_ADDR: w_cmd_nxt = instr(w_line_nxt ? LCD_DDRAM_L1 : LCD_DDRAM_L0);
        ST_CLR:  w_cmd_nxt = instr(LCD_CLEAR);
        ST_HOME: w_cmd_nxt = instr(LCD_DDRAM_L0);
        default: w_cmd_valid_nxt = 1'b0;
      endcase
    end
  end

  assign bus.cmd_o        = r_cmd;
  assign bus.cmd_valid_o  = r_cmd_valid;
  assign bus.char_ready_o = w_char_ready;
  assign bus.init_done_o  = r_init_done;
  assign bus.col_o        = r_col;
  assign bus.line_o       = r_line;

endmodule

// File: tb/tb_lcd_seq.sv
// Directed + randomized bench for lcd_seq against a queue-based model of the display cursor.
module tb_lcd_seq;
  localparam int COLS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_seq_if bus();
  lcd_seq #(.COLS(COLS)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  int         n_chk = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         m_col = 0;
  int         m_line = 0;
  bit         rand_rdy = 1'b0;
  logic [8:0] p_cmd = '0;
  logic       p_vld = 1'b0;
  logic       p_xfer = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // model: what the display should receive for each user action
  function automatic logic [8:0] addr_cmd(input int line);
    return (line != 0) ? 9'h0C0 : 9'h080;
  endfunction

  function automatic void m_init();
    exp_q.push_back(9'h038); exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001); exp_q.push_back(9'h006);
  endfunction

  function automatic void m_char(input logic [7:0] c);
    if (c == 8'h0A) begin
      m_line = 1 - m_line; m_col = 0;
      exp_q.push_back(addr_cmd(m_line));
    end else begin
      exp_q.push_back({1'b1, c});
      m_col++;
      if (m_col == COLS) begin
        m_col = 0; m_line = 1 - m_line;
        exp_q.push_back(addr_cmd(m_line));
      end
    end
  endfunction

  function automatic void m_clear();
    exp_q.push_back(9'h001); exp_q.push_back(9'h080);
    m_col = 0; m_line = 0;
  endfunction

  // Inputs change just after posedge; the monitor samples at negedge what the next posedge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      p_vld = 1'b0; p_xfer = 1'b0;
    end else begin
      if (p_vld && !p_xfer) begin
        chk("hold_valid", 32'(bus.cmd_valid_o), 32'd1);
        chk("hold_cmd", 32'(bus.cmd_o), 32'(p_cmd));
      end
      p_vld  = bus.cmd_valid_o;
      p_cmd  = bus.cmd_o;
      p_xfer = bus.cmd_valid_o && bus.cmd_ready_i;
      if (p_xfer) got_q.push_back(bus.cmd_o);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) bus.cmd_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_q(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin tick(); n++; end
    repeat (4) tick();
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete(); exp_q.delete();
  endtask

  task automatic send_char(input logic [7:0] c);
    int n = 0;
    bus.char_valid_i = 1'b1; bus.char_i = c; #1;
    while (!bus.char_ready_o && n < 500) begin tick(); #1; n++; end
    chk("char_accept_timeout", 32'(n < 500), 32'd1);
    tick();
    if (c != 8'h0A) begin
      chk("char_latency_valid", 32'(bus.cmd_valid_o), 32'd1);
      chk("char_latency_cmd", 32'(bus.cmd_o), 32'({1'b1, c}));
    end
    bus.char_valid_i = 1'b0;
    m_char(c);
  endtask

  task automatic pulse_clear();
    bus.clear_i = 1'b1; tick(); bus.clear_i = 1'b0;
    m_clear();
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_col"}, 32'(bus.col_o), 32'(m_col));
    chk({tag, "_line"}, 32'(bus.line_o), 32'(m_line));
  endtask

  initial begin
    int n;
    logic [7:0] c;
    bus.char_i = '0; bus.char_valid_i = 1'b0; bus.clear_i = 1'b0; bus.cmd_ready_i = 1'b1;
    #23;
    chk("rst_valid", 32'(bus.cmd_valid_o), 32'd0);
    chk("rst_cmd", 32'(bus.cmd_o), 32'd0);
    chk("rst_char_ready", 32'(bus.char_ready_o), 32'd0);
    chk("rst_init_done", 32'(bus.init_done_o), 32'd0);
    chk("rst_col", 32'(bus.col_o), 32'd0);
    chk("rst_line", 32'(bus.line_o), 32'd0);

    // release, let two init commands go, then abort with an asynchronous reset
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    chk("first_valid", 32'(bus.cmd_valid_o), 32'd1);
    chk("first_cmd", 32'(bus.cmd_o), 32'h038);
    n = 0;
    while (got_q.size() < 2 && n < 100) begin tick(); n++; end
    #2 rst_n = 1'b0; #1;
    chk("async_rst_valid", 32'(bus.cmd_valid_o), 32'd0);
    chk("async_rst_cmd", 32'(bus.cmd_o), 32'd0);
    got_q.delete();
    tick(); tick();
    rst_n = 1'b1; bus.clear_i = 1'b1;  // ignored during INIT
    tick(); bus.clear_i = 1'b0;
    chk("restart_cmd", 32'(bus.cmd_o), 32'h038);
    m_init();
    check_q("init");
    chk("init_done", 32'(bus.init_done_o), 32'd1);
    chk("ready_after_init", 32'(bus.char_ready_o), 32'd1);
    chk_cursor("init");

    send_char(8'h41);
    check_q("char_A");
    chk_cursor("char_A");

    pulse_clear();
    check_q("clear1");
    for (int i = 0; i < 16; i++) send_char(8'(8'h30 + i));
    check_q("line_wrap0");
    chk_cursor("line_wrap0");
    for (int i = 0; i < 16; i++) send_char(8'(8'h40 + i));
    check_q("line_wrap1");
    chk_cursor("line_wrap1");

    for (int i = 0; i < 5; i++) send_char(8'(8'h61 + i));
    check_q("five");
    chk_cursor("five");
    send_char(8'h0A);
    check_q("newline");
    chk_cursor("newline");

    rand_rdy = 1'b1;
    repeat (60) begin
      c = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(32, 126));
      send_char(c);
    end
    check_q("random");
    chk_cursor("random");
    rand_rdy = 1'b0;

    // driver stall with a clear arriving behind a pending data write
    bus.cmd_ready_i = 1'b0;
    send_char(8'h48);
    for (int i = 0; i < 50; i++) begin
      bus.clear_i = (i == 10);
      tick();
    end
    bus.clear_i = 1'b0;
    chk("stall_cmd", 32'(bus.cmd_o), 32'h148);
    chk("stall_valid", 32'(bus.cmd_valid_o), 32'd1);
    chk("stall_char_ready", 32'(bus.char_ready_o), 32'd0);
    m_clear();
    bus.cmd_ready_i = 1'b1;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 100) begin
      chk("clr_char_ready", 32'(bus.char_ready_o), 32'd0);
      tick(); n++;
    end
    chk("clr_done_char_ready", 32'(bus.char_ready_o), 32'd1);
    check_q("stall_clear");
    chk_cursor("stall_clear");

    // clear wins over a simultaneous character in READY
    bus.char_valid_i = 1'b1; bus.char_i = 8'h5A; bus.clear_i = 1'b1; #1;
    chk("clr_prio_ready", 32'(bus.char_ready_o), 32'd0);
    tick();
    bus.clear_i = 1'b0; bus.char_valid_i = 1'b0;
    m_clear();
    check_q("clr_vs_char");
    chk_cursor("clr_vs_char");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
